inv_clarkpark: RTL
==================

# inv_clarkpark

- Inverse Park plus inverse Clarke transform: takes a rotating-frame (d, q) sample and the rotor angle sine/cosine, and returns the three-phase (a, b, c) sample.
- Sits on the modulator side of the FOC loop, mirroring the forward abc→dq path on the measurement side.
- Shares one signed multiplier across five sequential multiplications under a small FSM.
- Uses valid/ready handshakes on both input and output.

## Interface
Parameters:
- pw_io_width, 16, total width of every data input and output
- pw_io_decimal_width, 15, fractional bits of every data input and output (Q1.15)
- p_sqrt3div2, 28378, fixed-point sqrt(3)/2 (0.8660 · 2^pw_io_decimal_width)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- i_valid  in  1  input sample valid
- i_ready  out  1  block can accept a sample
- isp_d  in  pw_io_width  signed d component
- isp_q  in  pw_io_width  signed q component
- ip_sine  in  pw_io_width  angle sine, interpreted as signed
- ip_cosine  in  pw_io_width  angle cosine, interpreted as signed
- o_valid  out  1  output sample valid
- o_ready  in  1  downstream accepts the sample
- osp_a  out  pw_io_width  signed phase a
- osp_b  out  pw_io_width  signed phase b
- osp_c  out  pw_io_width  signed phase c

## Operation
- **Input transfer:** occurs on a rising edge with i_valid && i_ready. isp_d, isp_q, ip_sine and ip_cosine are captured into internal registers, so inputs may change after acceptance.
- **Math:**
  - alpha = d·cos − q·sin
  - beta = d·sin + q·cos
  - a = alpha
  - b = −(alpha>>>1) + k
  - c = −(alpha>>>1) − k
  - k = (p_sqrt3div2·beta) >>> pw_io_decimal_width
- **Arithmetic:**
  - Products are 2·pw_io_width signed.
  - The accumulator is 2·pw_io_width+1 signed.
  - Every >>> is arithmetic, so results truncate toward −inf.
  - alpha and beta are saturated to pw_io_width after shifting.
  - b and c are computed in pw_io_width+2 bits, then saturated.
  - Saturation range is [−2^(pw_io_width−1), 2^(pw_io_width−1)−1].
- **FSM states:** IDLE, M0, M1, M2, M3, M4, OUT.
  - IDLE: i_ready=1. On a transfer → M0.
  - M0: acc ← d·cos → M1.
  - M1: alpha ← sat((acc − q·sin)>>>F) → M2.
  - M2: acc ← d·sin → M3.
  - M3: beta ← sat((acc + q·cos)>>>F) → M4.
  - M4: k computed; osp_a/b/c registered; o_valid←1 → OUT.
  - OUT: outputs held stable while o_ready=0. When o_ready=1 → IDLE, o_valid←0, i_ready←1.
- **i_valid outside IDLE:** ignored, with no side effects.
- **Reset:**
  - State → IDLE.
  - o_valid=0, i_ready=0, osp_a/b/c=0, acc/alpha/beta=0.
  - i_ready rises on the first edge after reset deasserts.
  - Reset mid-operation drops the in-flight sample. No o_valid is produced for it.

## Timing
- **Latency:** o_valid is high 5 cycles after the accepting edge (accept edge E0; outputs registered at E5).
- **Throughput:** with o_ready tied high, one sample per 7 cycles. E6 completes the output transfer; E7 is the earliest next acceptance.
- **Handshake ordering:** i_ready and o_valid are never both 1.
- **Output stability:** osp_a/b/c change only on the edge where o_valid rises.
- **Registered outputs:** all outputs come from registers; there is no combinational path from input to output.

## Structure
- **Shared package** (alongside the forward transform's constants):
  - pw_io_width / pw_io_decimal_width defaults
  - p_sqrt3div2 constant
  - FSM state enum
  - a saturate-to-width function
- **Sub-module fxp_sat:** a parameterised signed saturator (in width, out width), instantiated for alpha, beta, b and c.
- **Multiplier:** a single shared multiplier, operands muxed by state. It is not a separate module.

## Test plan
- d=16384, q=0, cos=32767, sin=0 -> a=16383, b=−8191, c=−8191; o_valid exactly 5 cycles after acceptance.
- d=0, q=16384, cos=32767, sin=0 -> a=0, b=14188, c=−14188.
- d=−1, q=0, cos=32767, sin=0 (floor rounding) -> a=−1, b=1, c=1.
- Saturation:
  - d=q=32767, cos=sin=23170 -> beta saturates to 32767; a=0, b=28377, c=−28377.
  - d=−32768, q=32767, cos=32767, sin=0 -> a=−32767, b=32767 (saturated), c=−11992.
- Backpressure:
  - Hold o_ready=0 for 10 cycles with i_valid high -> outputs stable, i_ready=0, no second sample accepted.
  - Then o_ready=1 -> one transfer; i_ready=1 the next cycle.
- Reset:
  - Assert reset in state M2 -> next cycle o_valid=0, outputs 0, i_ready=0.
  - After release, i_ready=1; a fresh sample produces correct results.

Source files
------------

// File: rtl/inv_clarkpark_pkg.sv
// Shared constants, FSM state type and saturation helper for the Clarke/Park transforms.
package inv_clarkpark_pkg;

   localparam int pc_io_width         = 16;
   localparam int pc_io_decimal_width = 15;
   // sqrt(3)/2 in Q1.15
   localparam int pc_sqrt3div2        = 28378;

   typedef enum logic [2:0] {
      StIdle,
      StM0,
      StM1,
      StM2,
      StM3,
      StM4,
      StOut
   } state_t;

   // Clamp a full-precision accumulator value to the io width.
   function automatic logic signed [pc_io_width-1:0] sat_io(
      input logic signed [2*pc_io_width:0] x
   );
      logic signed [2*pc_io_width:0] hi;
      logic signed [2*pc_io_width:0] lo;
      hi = (2*pc_io_width+1)'((1 << (pc_io_width - 1)) - 1);
      lo = -(2*pc_io_width+1)'(1 << (pc_io_width - 1));
      if (x > hi) begin
         return {1'b0, {(pc_io_width-1){1'b1}}};
      end else if (x < lo) begin
         return {1'b1, {(pc_io_width-1){1'b0}}};
      end else begin
         return x[pc_io_width-1:0];
      end
   endfunction

endpackage

// File: rtl/inv_clarkpark_fxp_sat.sv
// Parameterised signed saturator: narrows pw_in bits to pw_out bits with clamping.
module fxp_sat
   import inv_clarkpark_pkg::*;
#(
   parameter int pw_in  = 2*pc_io_width+1,
   parameter int pw_out = pc_io_width
) (
   input  logic signed [pw_in-1:0]  din,
   output logic signed [pw_out-1:0] dout
);

   // In range when every dropped bit equals the retained sign bit.
   always_comb begin
      if (din[pw_in-1:pw_out-1] == {(pw_in-pw_out+1){din[pw_in-1]}}) begin
         dout = din[pw_out-1:0];
      end else if (din[pw_in-1]) begin
         dout = {1'b1, {(pw_out-1){1'b0}}};
      end else begin
         dout = {1'b0, {(pw_out-1){1'b1}}};
      end
   end

endmodule

// File: rtl/inv_clarkpark.sv
// Inverse Park + inverse Clarke: (d, q, sin, cos) -> (a, b, c) with one shared multiplier.
module inv_clarkpark
   import inv_clarkpark_pkg::*;
#(
   parameter int pw_io_width         = pc_io_width,
   parameter int pw_io_decimal_width = pc_io_decimal_width,
   parameter int p_sqrt3div2         = pc_sqrt3div2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          i_valid,
   output logic                          i_ready,
   input  logic signed [pw_io_width-1:0] isp_d,
   input  logic signed [pw_io_width-1:0] isp_q,
   input  logic        [pw_io_width-1:0] ip_sine,
   input  logic        [pw_io_width-1:0] ip_cosine,
   output logic                          o_valid,
   input  logic                          o_ready,
   output logic signed [pw_io_width-1:0] osp_a,
   output logic signed [pw_io_width-1:0] osp_b,
   output logic signed [pw_io_width-1:0] osp_c
);

   localparam int aw = 2*pw_io_width+1;  // accumulator width
   localparam int bw = pw_io_width+2;    // b/c working width
   localparam logic signed [pw_io_width-1:0] sqrt3_op = pw_io_width'(p_sqrt3div2);

   state_t                          state_q;
   logic signed [pw_io_width-1:0]   d_q, q_q, sin_q, cos_q;
   logic signed [pw_io_width-1:0]   alpha_q, beta_q;
   logic signed [aw-1:0]            acc_q;

   logic signed [pw_io_width-1:0]   mul_a, mul_b;
   logic signed [2*pw_io_width-1:0] prod;
   logic signed [aw-1:0]            prod_ext;
   logic signed [aw-1:0]            alpha_sum, beta_sum, alpha_shift, beta_shift;
   logic signed [pw_io_width-1:0]   alpha_sat, beta_sat, b_sat, c_sat;
   logic signed [2*pw_io_width-1:0] k_full;
   logic signed [bw-1:0]            k, alpha_ext, half_alpha, b_wide, c_wide;
   logic        [2*pw_io_width-bw-1:0] k_unused;

   // Route the operand pair for the current step into the shared multiplier.
   always_comb begin
      mul_a = '0;
      mul_b = '0;
      case (state_q)
         StM0: begin mul_a = d_q;      mul_b = cos_q;  end
         StM1: begin mul_a = q_q;      mul_b = sin_q;  end
         StM2: begin mul_a = d_q;      mul_b = sin_q;  end
         StM3: begin mul_a = q_q;      mul_b = cos_q;  end
         StM4: begin mul_a = sqrt3_op; mul_b = beta_q; end
         default: ;
      endcase
   end

   assign prod        = mul_a * mul_b;
   assign prod_ext    = {prod[2*pw_io_width-1], prod};
   assign alpha_sum   = acc_q - prod_ext;
   assign beta_sum    = acc_q + prod_ext;
   assign alpha_shift = alpha_sum >>> pw_io_decimal_width;
   assign beta_shift  = beta_sum >>> pw_io_decimal_width;

   // k = sqrt(3)/2 * beta never exceeds the io range, so the top bits are sign copies.
   assign k_full   = prod >>> pw_io_decimal_width;
   assign k        = k_full[bw-1:0];
   assign k_unused = k_full[2*pw_io_width-1:bw];

   assign alpha_ext  = {{2{alpha_q[pw_io_width-1]}}, alpha_q};
   assign half_alpha = alpha_ext >>> 1;
   assign b_wide     = k - half_alpha;
   assign c_wide     = -half_alpha - k;

   fxp_sat #(.pw_in(aw), .pw_out(pw_io_width)) u_sat_alpha (.din(alpha_shift), .dout(alpha_sat));
   fxp_sat #(.pw_in(aw), .pw_out(pw_io_width)) u_sat_beta  (.din(beta_shift),  .dout(beta_sat));
   fxp_sat #(.pw_in(bw), .pw_out(pw_io_width)) u_sat_b     (.din(b_wide),      .dout(b_sat));
   fxp_sat #(.pw_in(bw), .pw_out(pw_io_width)) u_sat_c     (.din(c_wide),      .dout(c_sat));

   // Sequencer: capture, four multiply steps, k step with output register, then handshake out.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         i_ready <= 1'b0;
         o_valid <= 1'b0;
         osp_a   <= '0;
         osp_b   <= '0;
         osp_c   <= '0;
         acc_q   <= '0;
         alpha_q <= '0;
         beta_q  <= '0;
         d_q     <= '0;
         q_q     <= '0;
         sin_q   <= '0;
         cos_q   <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (i_valid && i_ready) begin
                  d_q     <= isp_d;
                  q_q     <= isp_q;
                  sin_q   <= ip_sine;
                  cos_q   <= ip_cosine;
                  i_ready <= 1'b0;
                  state_q <= StM0;
               end else begin
                  i_ready <= 1'b1;
               end
            end
            StM0: begin
               acc_q   <= prod_ext;
               state_q <= StM1;
            end
            StM1: begin
               alpha_q <= alpha_sat;
               state_q <= StM2;
            end
            StM2: begin
               acc_q   <= prod_ext;
               state_q <= StM3;
            end
            StM3: begin
               beta_q  <= beta_sat;
               state_q <= StM4;
            end
            StM4: begin
               osp_a   <= alpha_q;
               osp_b   <= b_sat;
               osp_c   <= c_sat;
               o_valid <= 1'b1;
               state_q <= StOut;
            end
            StOut: begin
               if (o_ready) begin
                  o_valid <= 1'b0;
                  i_ready <= 1'b1;
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
